// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_pkg
//  Brief    : Shared types and default sizing for the TDM serial demultiplexer.
//  Revision : 1.0  initial release
// ============================================================================
package tdm_pkg;

    // Default slots per frame and data bits per slot
    localparam int DEF_NCH = 4;
    localparam int DEF_W   = 8;

    // Receiver state: hunting for the frame marker, or receiving slot bits
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tdm_state_e;

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_shift.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_shift
//  Brief    : W-bit serial-in / parallel-out shift register, MSB first, with
//             enable and synchronous clear. word_o presents the value the
//             register takes at the coming edge, so a slot's final bit is
//             visible in the same cycle it is sampled.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_shift
    import tdm_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         sin_i,
    output logic [W-1:0] word_o
);

    logic [W-1:0] shreg_q;
    logic [W-1:0] shreg_d;

    // Clear with enable loads the incoming bit as the first bit of a new word
    always_comb begin
        shreg_d = shreg_q;
        if (clr_i) begin
            shreg_d = en_i ? {{(W-1){1'b0}}, sin_i} : '0;
        end else if (en_i) begin
            shreg_d = {shreg_q[W-2:0], sin_i};
        end
    end

    // Register update
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign word_o = shreg_d;

endmodule : tdm_shift
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux
//  Brief    : Serial TDM frame demultiplexer. Hunts for fsync, then slices the
//             qualified bit stream into NCH slots of W bits, presenting each
//             completed word with its channel index for one cycle.
//  Options  : TDM_DEMUX_PARITY_EN - each slot carries a trailing even-parity
//             bit and the parity_err strobe port is added.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int W   = DEF_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din,
    input  logic                    din_en,
    input  logic                    fsync,
    output logic [W-1:0]            out_data,
    output logic [$clog2(NCH)-1:0]  out_ch,
    output logic                    out_valid,
    output logic                    frame_done,
    output logic                    sync_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic                    parity_err
`endif
);

    localparam int CW = $clog2(NCH);
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT_LEN = W + 1;
`else
    localparam int SLOT_LEN = W;
`endif
    localparam int BCW = $clog2(SLOT_LEN + 1);

    localparam logic [BCW-1:0] C_LAST_BIT  = BCW'(SLOT_LEN - 1);
    localparam logic [BCW-1:0] C_DATA_BITS = BCW'(W);
    localparam logic [CW-1:0]  C_LAST_SLOT = CW'(NCH - 1);

    tdm_state_e      state_q,  state_d;
    logic [CW-1:0]   slot_q,   slot_d;
    logic [BCW-1:0]  bitcnt_q, bitcnt_d;
    logic [W-1:0]    out_data_q,   out_data_d;
    logic [CW-1:0]   out_ch_q,     out_ch_d;
    logic            out_valid_q,  out_valid_d;
    logic            frame_done_q, frame_done_d;
    logic            sync_err_q,   sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
    logic            parity_err_q, parity_err_d;
`endif

    logic            w_in_shift;
    logic            w_start;
    logic            w_last_bit;
    logic            w_last_slot;
    logic            w_resync;
    logic            w_data_bit;
    logic            w_sh_en;
    logic            w_sh_clr;
    logic [W-1:0]    w_sh_word;

    assign w_in_shift  = (state_q == SHIFT);
    assign w_start     = din_en & fsync & ~w_in_shift;
    assign w_last_bit  = (bitcnt_q == C_LAST_BIT);
    assign w_last_slot = (slot_q == C_LAST_SLOT);
    // fsync on the frame's final bit is simply that bit; anywhere else in a
    // frame it means we lost alignment and must restart from slot 0
    assign w_resync    = din_en & fsync & w_in_shift & ~(w_last_bit & w_last_slot);
    // The trailing parity bit (when present) is not shifted into the word
    assign w_data_bit  = (bitcnt_q < C_DATA_BITS);

    assign w_sh_clr = w_start | w_resync;
    assign w_sh_en  = w_start | w_resync | (din_en & w_in_shift & w_data_bit);

    tdm_shift #(
        .W      (W)
    ) u_shift (
        .clk    (clk),
        .rst    (rst),
        .en_i   (w_sh_en),
        .clr_i  (w_sh_clr),
        .sin_i  (din),
        .word_o (w_sh_word)
    );

    // Next-state: frame hunting, slot/bit counting and output capture
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        bitcnt_d     = bitcnt_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        sync_err_d   = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (din_en) begin
            case (state_q)
                IDLE: begin
                    if (fsync) begin
                        state_d  = SHIFT;
                        slot_d   = '0;
                        bitcnt_d = BCW'(1);
                    end
                end
                SHIFT: begin
                    if (w_resync) begin
                        sync_err_d = 1'b1;
                        slot_d     = '0;
                        bitcnt_d   = BCW'(1);
                    end else if (w_last_bit) begin
                        out_valid_d = 1'b1;
                        out_data_d  = w_sh_word;
                        out_ch_d    = slot_q;
                        bitcnt_d    = '0;
`ifdef TDM_DEMUX_PARITY_EN
                        parity_err_d = (^w_sh_word) ^ din;
`endif
                        if (w_last_slot) begin
                            frame_done_d = 1'b1;
                            slot_d       = '0;
                            state_d      = IDLE;
                        end else begin
                            slot_d = slot_q + CW'(1);
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + BCW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset wins over every input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            bitcnt_q     <= '0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            bitcnt_q     <= bitcnt_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule : tdm_demux
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux
//  Brief    : Self-checking bench for tdm_demux (NCH=4, W=8). Expected words
//             are queued as the last bit of each slot is driven and checked,
//             including the exact output cycle, when out_valid appears.
//  Options  : TDM_DEMUX_PARITY_EN - adds parity bits and parity_err checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdm_demux;

    localparam int NCH = 4;
    localparam int W   = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SL = W + 1;
`else
    localparam int SL = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         din;
    logic         din_en;
    logic         fsync;
    logic [W-1:0] out_data;
    logic [1:0]   out_ch;
    logic         out_valid;
    logic         frame_done;
    logic         sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic         parity_err;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] data;
        int           ch;
        logic         done;
        logic         perr;
        int           cyc;
    } exp_t;

    typedef struct {
        logic [NCH-1:0][W-1:0] d;
        int                    stall_slot;
        int                    stall_bit;
        int                    stall_len;
    } vec_t;

    exp_t sb[$];
    vec_t tab[4];

    tdm_demux #(
        .NCH        (NCH),
        .W          (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_en     (din_en),
        .fsync      (fsync),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err)
`ifdef TDM_DEMUX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: every out_valid must match the oldest queued word
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data",     32'(out_data),   32'(e.data));
                chk("out_ch",       32'(out_ch),     e.ch);
                chk("frame_done",   32'(frame_done), 32'(e.done));
                chk("output_cycle", cyc,             e.cyc);
`ifdef TDM_DEMUX_PARITY_EN
                chk("parity_err",   32'(parity_err), 32'(e.perr));
`endif
            end
        end else if (frame_done === 1'b1) begin
            chk("frame_done_without_valid", 32'(frame_done), 32'd0);
        end
    end

    task automatic drive(input logic b, input logic fs);
        din    = b;
        fsync  = fs;
        din_en = 1'b1;
        @(posedge clk);
        #1;
        din_en = 1'b0;
        fsync  = 1'b0;
    endtask

    // Unqualified cycles with junk on din/fsync; nothing may move
    task automatic stall(input int n);
        din_en = 1'b0;
        for (int k = 0; k < n; k++) begin
            din   = 1'($urandom);
            fsync = 1'($urandom);
            @(posedge clk);
            #1;
        end
        fsync = 1'b0;
    endtask

    task automatic send_slot(input logic [W-1:0] v, input int ch, input bit fs_first,
                             input bit fs_last, input bit flip, input int stall_at,
                             input int stall_len);
        logic b;
        logic fs;
        exp_t e;
        for (int i = 0; i < SL; i++) begin
            if (i == stall_at) stall(stall_len);
            if (i < W) b = v[W-1-i];
            else       b = (^v) ^ flip;
            fs = (fs_first && i == 0) || (fs_last && i == SL - 1);
            if (i == SL - 1) begin
                e.data = v;
                e.ch   = ch;
                e.done = (ch == NCH - 1);
                e.perr = flip;
                e.cyc  = cyc + 1;
                sb.push_back(e);
            end
            drive(b, fs);
        end
    endtask

    task automatic send_bits(input logic [W-1:0] v, input int n, input bit fs_first);
        for (int i = 0; i < n; i++) drive(v[W-1-i], fs_first && i == 0);
    endtask

    task automatic send_frame(input vec_t f);
        for (int k = 0; k < NCH; k++)
            send_slot(f.d[k], k, k == 0, 1'b0, 1'b0,
                      (k == f.stall_slot) ? f.stall_bit : -1, f.stall_len);
    endtask

    initial begin
        rst    = 1'b1;
        din    = 1'b0;
        din_en = 1'b0;
        fsync  = 1'b0;

        tab[0] = '{d: {8'h01, 8'hFF, 8'h3C, 8'hA5}, stall_slot: -1, stall_bit: 0, stall_len: 0};
        tab[1] = '{d: {8'h01, 8'hFF, 8'h3C, 8'hA5}, stall_slot:  1, stall_bit: 3, stall_len: 3};
        tab[2] = '{d: {8'h7E, 8'h00, 8'hC3, 8'h5A}, stall_slot:  3, stall_bit: 0, stall_len: 1};
        tab[3] = '{d: {8'hAA, 8'h55, 8'h01, 8'h80}, stall_slot:  0, stall_bit: 7, stall_len: 2};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_data",   32'(out_data),   32'd0);
        chk("reset_out_ch",     32'(out_ch),     32'd0);
        chk("reset_out_valid",  32'(out_valid),  32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_sync_err",   32'(sync_err),   32'd0);
        rst = 1'b0;

        // Table: clean frame, and the same frame with stalls in various places
        for (int t = 0; t < 4; t++) begin
            send_frame(tab[t]);
            stall(2);
        end
        chk("sync_err_after_clean_frames", 32'(sync_err), 32'd0);

        // fsync on the very last bit of the frame is not a resync
        send_slot(8'h12, 0, 1'b1, 1'b0, 1'b0, -1, 0);
        send_slot(8'h34, 1, 1'b0, 1'b0, 1'b0, -1, 0);
        send_slot(8'h56, 2, 1'b0, 1'b0, 1'b0, -1, 0);
        send_slot(8'h78, 3, 1'b0, 1'b1, 1'b0, -1, 0);
        stall(1);
        chk("sync_err_fsync_on_last_bit", 32'(sync_err), 32'd0);

        // Back-to-back frames with no gap after frame_done
        send_frame(tab[0]);
        send_frame(tab[2]);
        stall(2);
        chk("sync_err_back_to_back", 32'(sync_err), 32'd0);

        // Early fsync at bit 5 of slot 2: slot 2 dropped, restart at slot 0
        send_slot(8'h11, 0, 1'b1, 1'b0, 1'b0, -1, 0);
        send_slot(8'h22, 1, 1'b0, 1'b0, 1'b0, -1, 0);
        send_bits(8'h33, 5, 1'b0);
        send_slot(8'h5A, 0, 1'b1, 1'b0, 1'b0, -1, 0);
        send_slot(8'h6B, 1, 1'b0, 1'b0, 1'b0, -1, 0);
        send_slot(8'h7C, 2, 1'b0, 1'b0, 1'b0, -1, 0);
        send_slot(8'h8D, 3, 1'b0, 1'b0, 1'b0, -1, 0);
        stall(2);
        chk("sync_err_set", 32'(sync_err), 32'd1);
        send_frame(tab[1]);
        stall(1);
        chk("sync_err_sticky", 32'(sync_err), 32'd1);

        // Reset mid slot 1 with a qualified fsync present: reset must win
        send_slot(8'hC9, 0, 1'b1, 1'b0, 1'b0, -1, 0);
        send_bits(8'h96, 4, 1'b0);
        rst    = 1'b1;
        din_en = 1'b1;
        fsync  = 1'b1;
        din    = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        din_en = 1'b0;
        fsync  = 1'b0;
        chk("midreset_out_data",   32'(out_data),   32'd0);
        chk("midreset_out_ch",     32'(out_ch),     32'd0);
        chk("midreset_out_valid",  32'(out_valid),  32'd0);
        chk("midreset_frame_done", 32'(frame_done), 32'd0);
        chk("midreset_sync_err",   32'(sync_err),   32'd0);
        // Bits without fsync must be ignored in IDLE
        send_bits(8'hFF, 8, 1'b0);
        send_bits(8'h0F, 8, 1'b0);
        send_bits(8'hE7, 8, 1'b0);
        stall(1);
        send_frame(tab[3]);
        stall(2);
        chk("sync_err_after_reset_frame", 32'(sync_err), 32'd0);

`ifdef TDM_DEMUX_PARITY_EN
        // 0x07 has odd weight: parity bit 0 is wrong, parity bit 1 is right
        send_slot(8'h07, 0, 1'b1, 1'b0, 1'b1, -1, 0);
        send_slot(8'h07, 1, 1'b0, 1'b0, 1'b0, -1, 0);
        send_slot(8'hF0, 2, 1'b0, 1'b0, 1'b1, -1, 0);
        send_slot(8'h81, 3, 1'b0, 1'b0, 1'b0, -1, 0);
        stall(2);
`endif

        stall(4);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_tdm_demux
`default_nettype wire
